// File: rtl/spi_minion_pkg.sv
// spi_minion_pkg: SPI mode encodings and counter sizing shared by the minion
package spi_minion_pkg;
  localparam logic [1:0] MODE0 = 2'b00, MODE1 = 2'b01, MODE2 = 2'b10, MODE3 = 2'b11;
  function automatic int cnt_w(input int n);
    return $clog2(n + 2);
  endfunction
endpackage

// File: rtl/spi_minion_modes_if.sv
// spi_minion_modes_if: SPI pins plus push/pull fabric handshakes
interface spi_minion_modes_if #(parameter int nbits = 8);
  logic cs, sclk, mosi, miso, cpol, cpha;
  logic push_val, push_rdy, push_parity, pull_val, pull_rdy;
  logic frame_err, overflow, underflow;
  logic [nbits-1:0] push_msg, pull_msg;
  modport slave (
    input  cs, sclk, mosi, cpol, cpha, push_rdy, pull_val, pull_msg,
    output miso, push_val, push_msg, push_parity, pull_rdy, frame_err, overflow, underflow
  );
  modport master (
    output cs, sclk, mosi, cpol, cpha, push_rdy, pull_val, pull_msg,
    input  miso, push_val, push_msg, push_parity, pull_rdy, frame_err, overflow, underflow
  );
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer with registered rise/fall pulses
module spi_sync_edge #(
  parameter logic reset_value = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic r_s1, r_s2, r_d, r_rise, r_fall;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_s1   <= reset_value;
      r_s2   <= reset_value;
      r_d    <= reset_value;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= d;
      r_s2   <= r_s1;
      r_d    <= r_s2;
      r_rise <= r_s2 & ~r_d;
      r_fall <= ~r_s2 & r_d;
    end
  // q is the delayed copy so level and pulses line up in the same cycle
  assign q    = r_d;
  assign rise = r_rise;
  assign fall = r_fall;
endmodule

// File: rtl/spi_minion_modes.sv
// spi_minion_modes: four-mode SPI minion with push/pull handshakes, framing and parity checks
module spi_minion_modes
  import spi_minion_pkg::*;
#(
  parameter int nbits = 8
) (
  input logic clk,
  input logic reset,
  spi_minion_modes_if.slave bus
);
  localparam int CW = cnt_w(nbits);
  logic w_cs, w_cs_rise, w_cs_fall, w_sclk_rise, w_sclk_fall, w_mosi;
  logic w_sclk_unused, w_mosi_rise_unused, w_mosi_fall_unused;
  logic w_sample, w_shift, w_valid;
  logic [1:0] r_mode;
  logic [CW-1:0] r_cnt;
  logic r_shifted, r_push_val, r_push_parity, r_pull_rdy, r_frame_err, r_overflow, r_underflow;
  logic [nbits-1:0] r_in, r_out, r_push_msg;

  spi_sync_edge #(.reset_value(1'b1)) u_cs (
    .clk(clk), .reset(reset), .d(bus.cs), .q(w_cs), .rise(w_cs_rise), .fall(w_cs_fall)
  );
  spi_sync_edge #(.reset_value(1'b0)) u_sclk (
    .clk(clk), .reset(reset), .d(bus.sclk), .q(w_sclk_unused), .rise(w_sclk_rise), .fall(w_sclk_fall)
  );
  spi_sync_edge #(.reset_value(1'b0)) u_mosi (
    .clk(clk), .reset(reset), .d(bus.mosi), .q(w_mosi), .rise(w_mosi_rise_unused), .fall(w_mosi_fall_unused)
  );

  // modes 0 and 3 sample on rising sclk, modes 1 and 2 shift on rising sclk
  assign w_sample = ~w_cs & ((r_mode inside {MODE0, MODE3}) ? w_sclk_rise : w_sclk_fall);
  assign w_shift  = ~w_cs & ((r_mode inside {MODE1, MODE2}) ? w_sclk_rise : w_sclk_fall);
  assign w_valid  = w_cs_rise & (r_cnt == CW'(nbits));

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_mode        <= 2'b00;
      r_cnt         <= '0;
      r_shifted     <= 1'b0;
      r_in          <= '0;
      r_out         <= '0;
      r_push_val    <= 1'b0;
      r_push_msg    <= '0;
      r_push_parity <= 1'b0;
      r_pull_rdy    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_pull_rdy  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      if (w_cs_fall) begin
        r_mode      <= {bus.cpol, bus.cpha};
        r_cnt       <= '0;
        r_shifted   <= 1'b0;
        r_out       <= bus.pull_val ? bus.pull_msg : '0;
        r_pull_rdy  <= bus.pull_val;
        r_underflow <= ~bus.pull_val;
      end else begin
        if (w_sample) begin
          r_in  <= {r_in[nbits-2:0], w_mosi};
          r_cnt <= (r_cnt == CW'(nbits + 1)) ? r_cnt : r_cnt + 1'b1;
        end
        // with cpha=1 the first leading edge must not disturb the preloaded MSB
        if (w_shift) begin
          if (r_mode[0] && !r_shifted) r_shifted <= 1'b1;
          else r_out <= {r_out[nbits-2:0], 1'b0};
        end
      end
      if (w_cs_rise && !w_valid) r_frame_err <= 1'b1;
      if (w_valid && (!r_push_val || bus.push_rdy)) begin
        r_push_val    <= 1'b1;
        r_push_msg    <= r_in;
        r_push_parity <= ^r_in;
      end else if (w_valid) r_overflow <= 1'b1;
      else if (r_push_val && bus.push_rdy) r_push_val <= 1'b0;
    end

  assign bus.miso        = r_out[nbits-1];
  assign bus.push_val    = r_push_val;
  assign bus.push_msg    = r_push_msg;
  assign bus.push_parity = r_push_parity;
  assign bus.pull_rdy    = r_pull_rdy;
  assign bus.frame_err   = r_frame_err;
  assign bus.overflow    = r_overflow;
  assign bus.underflow   = r_underflow;
endmodule

// File: doc/spi_minion_modes.md
Name: spi_minion_modes

Overview:
- Parametrised successor SPI minion: all four SPI modes (CPOL/CPHA selectable per frame), any word width, valid/ready handshakes on both sides.
- Adds frame-length checking, push overflow and pull underflow reporting, and whole-word parity.
- Sits between the external SPI pins and the on-chip message fabric (arbitrator/router), in the system clock domain.

Parameters:
- nbits, 8, SPI frame/word width in bits (≥2)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- cs  in  1  SPI chip select, active low, asynchronous to clk
- sclk  in  1  SPI clock, asynchronous
- mosi  in  1  SPI data in, asynchronous
- miso  out  1  SPI data out
- cpol  in  1  clock polarity, latched at frame start
- cpha  in  1  clock phase, latched at frame start
- push_val  out  1  received word valid
- push_rdy  in  1  downstream accepts word
- push_msg  out  nbits  received word
- push_parity  out  1  XOR of all push_msg bits, registered with push_msg
- pull_val  in  1  upstream has transmit word
- pull_rdy  out  1  one-cycle pulse: pull_msg consumed
- pull_msg  in  nbits  transmit word
- frame_err  out  1  one-cycle pulse: frame ended with bit count ≠ nbits
- overflow  out  1  one-cycle pulse: completed word dropped
- underflow  out  1  one-cycle pulse: frame started with pull_val=0

Behaviour:
- Reset: all flops clear immediately on reset=0. cs sync/prev reset to 1; sclk and mosi sync reset to 0. Outputs: push_val=0, push_msg=0, push_parity=0, pull_rdy=0, frame_err/overflow/underflow=0, miso=0, bit counter=0.
- Input conditioning:
  - cs, sclk and mosi each pass through 2-flop synchronizers.
  - Edge pulses are formed from the sync output and a delayed copy.
  - Latency: a pin change produces an edge pulse on the 3rd clk edge after the change.
- Timing requirement: sclk high and low phases are each ≥4 clk periods; mosi is stable across the sample edge.
- Frame start (cs falling pulse):
  - Latch cpol/cpha into mode registers.
  - Clear bit counter and the first-shift flag.
  - Load shreg_out with pull_msg if pull_val=1, else with 0 and pulse underflow.
  - Pulse pull_rdy only when pull_val=1.
- Edges (only while synced cs=0):
  - leading edge = rising if cpol=0, falling if cpol=1; trailing edge is the opposite.
  - Sample edge = leading edge if cpha=0, trailing edge if cpha=1.
  - Shift edge = the other one.
- Sample edge: shreg_in shifts left, mosi_sync enters the LSB. Bit counter increments and saturates at nbits+1.
- Shift edge: shreg_out shifts left with 0 fill.
  - With cpha=1, the first shift edge of a frame is suppressed, so the MSB is presented for the first trailing-edge sample.
- miso = shreg_out[nbits-1] at all times. It is not tri-stated; pad logic gates it with cs.
- Frame end (cs rising pulse):
  - Counter == nbits: frame is valid.
  - Otherwise: pulse frame_err, discard the word, leave push state untouched.
- Push holding register (one entry):
  - Valid frame with push_val=0, or push_val&push_rdy in the same cycle: load push_msg=shreg_in and push_parity=^shreg_in on the next edge; push_val=1.
  - Valid frame with push_val=1 and push_rdy=0: drop the new word, pulse overflow, keep the old word.
  - push_val&push_rdy with no frame end: push_val→0. push_msg holds its value.
- Latency: push_val rises 1 cycle after the cs rising pulse, i.e. 4 clk edges after the cs pin rises.
- cs edge pulses never coincide within a cycle (synchronized signal). sclk edges while cs=1 are ignored.
- Reset mid-frame: frame is abandoned; no push or frame_err afterwards. The first cs falling edge after release starts a clean frame.

Decomposition:
- Package spi_minion_pkg:
  - localparams MODE0..MODE3 as {cpol,cpha}.
  - Counter width function $clog2(nbits+2).
- Sub-module spi_sync_edge: 2-flop synchronizer plus posedge/negedge detect, parameter reset_value, async active-low reset. Instantiated three times.
- Shift registers and control stay inline in spi_minion_modes.

Test Plan:
- Mode 0, pull_msg=0xA5 with pull_val=1, master sends 0x3C → miso bits 1,0,1,0,0,1,0,1; pull_rdy one pulse; push_msg=0x3C, push_parity=0, push_val 4 clk edges after cs rises.
- Mode 3 and mode 1, same data → identical push_msg/miso sequences; with mode 1 the first miso bit is valid at the first trailing edge.
- Mode 2 short frame of 5 bits, then 9-bit frame → frame_err pulses twice, push_val stays 0.
- push_rdy=0, frames 0x11 then 0x22 → push_msg=0x11, overflow pulse on the second frame; then push_rdy=1 → 0x11 accepted, push_val=0.
- pull_val=0 at frame start → underflow pulse, no pull_rdy, miso=0 for all 8 bits, received word still pushed.
- reset=0 after 4 bits of a frame → all outputs at reset values immediately; after release, a full mode-0 frame 0xF0 gives push_msg=0xF0, push_parity=0.
